// File: rtl/cascade_time_counter.sv
`default_nettype none
// ============================================================================
// Module   : cascade_time_counter
// Brief    : hsec/sec/min/hour cascaded counter with prescaler, edit cursor,
//            lap capture; optional alarm via CASCADE_TIME_COUNTER_ALARM_EN.
// Revision : 1.0
// ============================================================================
module cascade_time_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 100,
    parameter int HOUR_MOD  = 24,
    parameter int HOUR_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_run,
    input  logic        i_down,
    input  logic        i_clear,
    input  logic        i_edit_en,
    input  logic        i_inc,
    input  logic        i_dec,
    input  logic        i_left,
    input  logic        i_right,
    input  logic        i_lap,
`ifdef CASCADE_TIME_COUNTER_ALARM_EN
    input  logic        i_alarm_arm,
    input  logic [23:0] i_alarm_time,
`endif
    output logic [23:0] o_time,
    output logic [23:0] o_disp,
    output logic [23:0] o_lap,
    output logic        o_lap_valid,
    output logic [3:0]  o_cursor,
    output logic        o_rollover,
    output logic        o_alarm
);

    localparam int            c_DIV      = CLK_HZ / TICK_HZ;
    localparam int            c_PW       = $clog2(c_DIV);
    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(c_DIV - 1);
    localparam logic [4:0]    c_HOUR_MAX = 5'(HOUR_MOD - 1);
    localparam logic [4:0]    c_HOUR_RST = 5'(HOUR_INIT);

    typedef enum logic [1:0] {
        CUR_HSEC = 2'd0,
        CUR_SEC  = 2'd1,
        CUR_MIN  = 2'd2,
        CUR_HOUR = 2'd3
    } cursor_t;

    logic [c_PW-1:0] pre_q,  pre_d;
    logic [6:0]      hsec_q, hsec_d;
    logic [5:0]      sec_q,  sec_d;
    logic [5:0]      min_q,  min_d;
    logic [4:0]      hour_q, hour_d;
    cursor_t         cur_q,  cur_d;
    logic [23:0]     lap_q,  lap_d;
    logic            lap_valid_q, lap_valid_d;
    logic            roll_q, roll_d;

    logic w_count_en;
    logic w_edit_val;

    assign w_count_en = i_run & ~i_edit_en;
    assign w_edit_val = i_edit_en & (i_inc | i_dec);

    always_comb begin
        pre_d       = pre_q;
        hsec_d      = hsec_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        cur_d       = cur_q;
        lap_d       = lap_q;
        lap_valid_d = lap_valid_q;
        roll_d      = 1'b0;

        if (i_clear) begin
            pre_d  = '0;
            hsec_d = 7'd0;
            sec_d  = 6'd0;
            min_d  = 6'd0;
            hour_d = c_HOUR_RST;
        end else if (w_edit_val) begin
            // Field-local adjust: wraps within the field, never carries.
            unique case (cur_q)
                CUR_HSEC: hsec_d = i_inc ? ((hsec_q == 7'd99) ? 7'd0 : hsec_q + 7'd1)
                                         : ((hsec_q == 7'd0) ? 7'd99 : hsec_q - 7'd1);
                CUR_SEC:  sec_d  = i_inc ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1)
                                         : ((sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1);
                CUR_MIN:  min_d  = i_inc ? ((min_q == 6'd59) ? 6'd0 : min_q + 6'd1)
                                         : ((min_q == 6'd0) ? 6'd59 : min_q - 6'd1);
                default:  hour_d = i_inc ? ((hour_q == c_HOUR_MAX) ? 5'd0 : hour_q + 5'd1)
                                         : ((hour_q == 5'd0) ? c_HOUR_MAX : hour_q - 5'd1);
            endcase
        end else if (i_edit_en) begin
            if (i_left) begin
                cur_d = cursor_t'(cur_q + 2'd1);
            end else if (i_right) begin
                cur_d = cursor_t'(cur_q - 2'd1);
            end
        end else if (w_count_en) begin
            if (pre_q == c_PRE_MAX) begin
                pre_d = '0;
                if (!i_down) begin
                    if (hsec_q != 7'd99) begin
                        hsec_d = hsec_q + 7'd1;
                    end else begin
                        hsec_d = 7'd0;
                        if (sec_q != 6'd59) begin
                            sec_d = sec_q + 6'd1;
                        end else begin
                            sec_d = 6'd0;
                            if (min_q != 6'd59) begin
                                min_d = min_q + 6'd1;
                            end else begin
                                min_d = 6'd0;
                                if (hour_q != c_HOUR_MAX) begin
                                    hour_d = hour_q + 5'd1;
                                end else begin
                                    hour_d = 5'd0;
                                    roll_d = 1'b1;
                                end
                            end
                        end
                    end
                end else begin
                    if (hsec_q != 7'd0) begin
                        hsec_d = hsec_q - 7'd1;
                    end else begin
                        hsec_d = 7'd99;
                        if (sec_q != 6'd0) begin
                            sec_d = sec_q - 6'd1;
                        end else begin
                            sec_d = 6'd59;
                            if (min_q != 6'd0) begin
                                min_d = min_q - 6'd1;
                            end else begin
                                min_d = 6'd59;
                                if (hour_q != 5'd0) begin
                                    hour_d = hour_q - 5'd1;
                                end else begin
                                    hour_d = c_HOUR_MAX;
                                    roll_d = 1'b1;
                                end
                            end
                        end
                    end
                end
            end else begin
                pre_d = pre_q + c_PW'(1);
            end
        end

        // Lap toggles independently of clear/edit/count and samples the pre-update time.
        if (i_lap) begin
            if (!lap_valid_q) begin
                lap_d       = o_time;
                lap_valid_d = 1'b1;
            end else begin
                lap_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q       <= '0;
            hsec_q      <= 7'd0;
            sec_q       <= 6'd0;
            min_q       <= 6'd0;
            hour_q      <= c_HOUR_RST;
            cur_q       <= CUR_HSEC;
            lap_q       <= 24'd0;
            lap_valid_q <= 1'b0;
            roll_q      <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            hsec_q      <= hsec_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            cur_q       <= cur_d;
            lap_q       <= lap_d;
            lap_valid_q <= lap_valid_d;
            roll_q      <= roll_d;
        end
    end

`ifdef CASCADE_TIME_COUNTER_ALARM_EN
    logic w_update;
    logic alarm_q, alarm_d;

    // Only genuine count updates qualify; clear and edits are excluded by construction.
    assign w_update = w_count_en & ~i_clear & (pre_q == c_PRE_MAX);
    assign alarm_d  = w_update & i_alarm_arm & (hsec_d == 7'd0)
                    & ({hour_d, min_d, sec_d} == i_alarm_time[23:7]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign o_alarm = alarm_q;
`else
    assign o_alarm = 1'b0;
`endif

    assign o_time      = {hour_q, min_q, sec_q, hsec_q};
    assign o_disp      = lap_valid_q ? lap_q : o_time;
    assign o_lap       = lap_q;
    assign o_lap_valid = lap_valid_q;
    assign o_cursor    = i_edit_en ? (4'b0001 << cur_q) : 4'b0000;
    assign o_rollover  = roll_q;

endmodule
`default_nettype wire
